p2_mem_read: RTL and testbench

P2_MEM_READ -- requirements
Module: p2_mem_read

---
 rtl/p2_mem_read.sv | 102 ++++++++++
 tb/tb_p2_mem_read.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/p2_mem_read.sv
// Pooling-2 output memory reader: sweeps WORDS addresses PASSES times toward the
// fully-connected MAC and tags each returned word with its pass and end-of-pass flag.
module p2_mem_read #(
    parameter int WORDS  = 16,
    parameter int PASSES = 10,
    parameter int RD_LAT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       ready,
    output logic [3:0] addr0,
    output logic       rd_en,
    output logic       data_valid,
    output logic       last,
    output logic [3:0] pass_idx,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t     state, state_nxt;
    logic [3:0] pass_cnt;
    logic [1:0] drain_cnt;
    logic       end_of_pass;
    logic       final_issue;
    logic       drain_end;

    logic       vld_pipe  [RD_LAT];
    logic       last_pipe [RD_LAT];
    logic [3:0] pidx_pipe [RD_LAT];

    always_comb begin
        end_of_pass = (addr0 == 4'(WORDS - 1));
        rd_en       = (state == READ) && enable && ready && !reset;
        final_issue = rd_en && end_of_pass && (pass_cnt == 4'(PASSES - 1));
        drain_end   = (state == DRAIN) && (drain_cnt == 2'(RD_LAT - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (enable) state_nxt = READ;
            READ:    if (final_issue) state_nxt = DRAIN;
            DRAIN:   if (drain_end) state_nxt = DONE;
            DONE:    state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr0     <= '0;
            pass_cnt  <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
        end else begin
            if (rd_en) begin
                if (end_of_pass) begin
                    addr0    <= '0;
                    pass_cnt <= final_issue ? '0 : pass_cnt + 4'd1;
                end else begin
                    addr0 <= addr0 + 4'd1;
                end
            end
            drain_cnt <= (state == DRAIN) ? drain_cnt + 2'd1 : '0;
            if (drain_end) done <= 1'b1;
        end
    end

    // Stage 0 is loaded every cycle; non-issue cycles push zeros so tags stay clean.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < RD_LAT; i++) begin
                vld_pipe[i]  <= 1'b0;
                last_pipe[i] <= 1'b0;
                pidx_pipe[i] <= '0;
            end
        end else begin
            vld_pipe[0]  <= rd_en;
            last_pipe[0] <= rd_en && end_of_pass;
            pidx_pipe[0] <= rd_en ? pass_cnt : '0;
            for (int unsigned i = 1; i < RD_LAT; i++) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
                pidx_pipe[i] <= pidx_pipe[i-1];
            end
        end
    end

    always_comb begin
        data_valid = vld_pipe[RD_LAT-1] && !reset;
        last       = last_pipe[RD_LAT-1] && data_valid;
        pass_idx   = data_valid ? pidx_pipe[RD_LAT-1] : '0;
    end

endmodule

// File: tb/tb_p2_mem_read.sv
// Directed bench for p2_mem_read: RD_LAT=1 and RD_LAT=3 instances share stimulus;
// free run, ready stall, enable pause, wrap tagging and mid-run reset.
module tb_p2_mem_read;

    logic       clk = 1'b0;
    logic       reset, enable, ready;
    logic [3:0] addr0_1, pass_idx_1, addr0_3, pass_idx_3;
    logic       rd_en_1, data_valid_1, last_1, done_1;
    logic       rd_en_3, data_valid_3, last_3, done_3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    p2_mem_read #(.WORDS(16), .PASSES(10), .RD_LAT(1)) u_lat1 (
        .clk(clk), .reset(reset), .enable(enable), .ready(ready),
        .addr0(addr0_1), .rd_en(rd_en_1), .data_valid(data_valid_1),
        .last(last_1), .pass_idx(pass_idx_1), .done(done_1)
    );

    p2_mem_read #(.WORDS(16), .PASSES(10), .RD_LAT(3)) u_lat3 (
        .clk(clk), .reset(reset), .enable(enable), .ready(ready),
        .addr0(addr0_3), .rd_en(rd_en_3), .data_valid(data_valid_3),
        .last(last_3), .pass_idx(pass_idx_3), .done(done_3)
    );

    task automatic chk(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag, input int cyc);
        chk({tag, ".rd_en1"}, cyc, 32'(rd_en_1), 0);
        chk({tag, ".dv1"},    cyc, 32'(data_valid_1), 0);
        chk({tag, ".last1"},  cyc, 32'(last_1), 0);
        chk({tag, ".pidx1"},  cyc, 32'(pass_idx_1), 0);
        chk({tag, ".done1"},  cyc, 32'(done_1), 0);
        chk({tag, ".dv3"},    cyc, 32'(data_valid_3), 0);
        chk({tag, ".last3"},  cyc, 32'(last_3), 0);
        chk({tag, ".pidx3"},  cyc, 32'(pass_idx_3), 0);
        chk({tag, ".done3"},  cyc, 32'(done_3), 0);
        chk({tag, ".rd_en3"}, cyc, 32'(rd_en_3), 0);
    endtask

    // Caller has set up cycle 0 (reset low, enable/ready high). A window of
    // win_len cycles starting at win_start drops ready (or enable when use_en).
    // abort_at>0 raises reset during that cycle and returns after checking it.
    task automatic run(input string tag, input int win_start, input int win_len,
                       input bit use_en, input int abort_at, input int ncyc);
        bit   hv [0:255];
        bit   hl [0:255];
        int   hp [0:255];
        int   k = 0;
        int   lcyc = 0;
        bit   stalled, er;
        int   ea, ep;
        for (int i = 0; i < 256; i++) begin
            hv[i] = 0; hl[i] = 0; hp[i] = 0;
        end
        for (int c = 1; c <= ncyc; c++) begin
            @(posedge clk);
            #1;
            stalled = (c >= win_start) && (c < win_start + win_len);
            if (c == abort_at) begin
                reset = 1'b1; enable = 1'b1; ready = 1'b1;
            end else begin
                reset  = 1'b0;
                enable = !(stalled && use_en);
                ready  = !(stalled && !use_en);
            end
            @(negedge clk);
            if (c == abort_at) begin
                chk_zero({tag, ".rst"}, c);
                return;
            end
            er = (k < 160) && !stalled;
            ea = (k < 160) ? k % 16 : 0;
            ep = k / 16;
            hv[c] = er;
            hl[c] = er && (k % 16 == 15);
            hp[c] = er ? ep : 0;
            chk({tag, ".rd_en1"}, c, 32'(rd_en_1), 32'(er));
            chk({tag, ".rd_en3"}, c, 32'(rd_en_3), 32'(er));
            chk({tag, ".addr1"},  c, 32'(addr0_1), 32'(ea));
            chk({tag, ".addr3"},  c, 32'(addr0_3), 32'(ea));
            chk({tag, ".dv1"},    c, 32'(data_valid_1), 32'(hv[c-1]));
            chk({tag, ".last1"},  c, 32'(last_1), 32'(hl[c-1]));
            chk({tag, ".pidx1"},  c, 32'(pass_idx_1), 32'(hp[c-1]));
            chk({tag, ".dv3"},    c, 32'(data_valid_3), (c >= 3) ? 32'(hv[c-3]) : 0);
            chk({tag, ".last3"},  c, 32'(last_3), (c >= 3) ? 32'(hl[c-3]) : 0);
            chk({tag, ".pidx3"},  c, 32'(pass_idx_3), (c >= 3) ? 32'(hp[c-3]) : 0);
            chk({tag, ".done1"},  c, 32'(done_1), 32'((lcyc != 0) && (c >= lcyc + 2)));
            chk({tag, ".done3"},  c, 32'(done_3), 32'((lcyc != 0) && (c >= lcyc + 4)));
            if (er) begin
                k++;
                if (k == 160) lcyc = c;
            end
        end
        chk({tag, ".issues"}, ncyc, 32'(k), 32'd160);
    endtask

    task automatic start_run(input string tag);
        @(posedge clk);
        #1;
        reset = 1'b0; enable = 1'b1; ready = 1'b1;
        @(negedge clk);
        chk_zero({tag, ".c0"}, 0);
    endtask

    task automatic do_reset(input string tag);
        @(posedge clk);
        #1;
        reset = 1'b1; enable = 1'b0; ready = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk_zero({tag, ".inrst"}, -1);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; ready = 1'b0;
        do_reset("free");
        start_run("free");
        run("free", 0, 0, 1'b0, 0, 172);

        do_reset("stall");
        start_run("stall");
        // addr 5 of pass 2 issues at cycle 38; ready low for cycles 39..41
        run("stall", 39, 3, 1'b0, 0, 175);

        do_reset("pause");
        start_run("pause");
        run("pause", 70, 5, 1'b1, 0, 176);

        do_reset("abort");
        start_run("abort");
        run("abort", 0, 0, 1'b0, 80, 80);
        start_run("rerun");
        run("rerun", 0, 0, 1'b0, 0, 172);

        // done is sticky and DONE ignores enable/ready
        @(posedge clk);
        #1;
        enable = 1'b0; ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("hold.done1", 0, 32'(done_1), 1);
        chk("hold.done3", 0, 32'(done_3), 1);
        chk("hold.rd_en1", 0, 32'(rd_en_1), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
